cpu_multicycle: RTL

CPU_MULTICYCLE -- requirements
Module: cpu_multicycle

---
 rtl/cpu_multicycle.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/cpu_multicycle.sv
// cpu_multicycle: four-phase multicycle core (FETCH -> DECODE -> EXECUTE -> WRITEBACK) with a debug register read port.
// Optional macro CPU_ILLEGAL_HALT_EN: undefined opcodes halt the core (illegal=1) instead of executing as NOP.

module cpu_multicycle #(
   parameter int WORD_SIZE = 8,
   parameter int ADDR_SIZE = 8,
   parameter int REG_COUNT = 8,
   localparam int RB = $clog2(REG_COUNT)
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     imem_req,
   output logic [ADDR_SIZE-1:0]     imem_addr,
   input  logic                     imem_ack,
   input  logic [2*WORD_SIZE-1:0]   imem_data,
   output logic [ADDR_SIZE-1:0]     pc,
   output logic                     halted,
   output logic                     illegal,
   input  logic [RB-1:0]            dbg_idx,
   output logic [WORD_SIZE-1:0]     dbg_data
);

   // Fetch handshake: imem_req is high for the whole FETCH state with imem_addr held at pc;
   // the transfer completes on the rising edge where imem_req and imem_ack are both high.

   localparam logic [4:0] OP_NOP  = 5'h00;
   localparam logic [4:0] OP_ADD  = 5'h01;
   localparam logic [4:0] OP_SUB  = 5'h02;
   localparam logic [4:0] OP_AND  = 5'h03;
   localparam logic [4:0] OP_OR   = 5'h04;
   localparam logic [4:0] OP_XOR  = 5'h05;
   localparam logic [4:0] OP_MOV  = 5'h06;
   localparam logic [4:0] OP_SET  = 5'h10;
   localparam logic [4:0] OP_JMP  = 5'h11;
   localparam logic [4:0] OP_JZ   = 5'h12;
   localparam logic [4:0] OP_HALT = 5'h1F;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_WRITEBACK,
      S_HALT
   } state_t;

   state_t                   state_q, state_d;
   logic [2*WORD_SIZE-1:0]   inst_q, inst_d;
   logic [ADDR_SIZE-1:0]     pc_q, pc_d;
   logic [WORD_SIZE-1:0]     regs_q [REG_COUNT];
   logic [WORD_SIZE-1:0]     regs_d [REG_COUNT];
   logic [WORD_SIZE-1:0]     op_a_q, op_a_d;
   logic [WORD_SIZE-1:0]     op_b_q, op_b_d;
   logic [WORD_SIZE-1:0]     result_q, result_d;
   logic                     flag_z_q, flag_z_d;
   logic                     flag_c_q, flag_c_d;
   logic                     wr_en_q, wr_en_d;
   logic                     jump_q, jump_d;
   logic                     halted_q, halted_d;
   logic                     illegal_q, illegal_d;

   logic [4:0]               opcode;
   logic [RB-1:0]            rx;
   logic [RB-1:0]            ry;
   logic [WORD_SIZE-1:0]     imm;
   logic [ADDR_SIZE-1:0]     jump_target;
   logic                     is_alu;
   logic                     is_write;
   logic [WORD_SIZE:0]       add_full;
   logic [WORD_SIZE-1:0]     alu_res;
   logic                     alu_c;

   assign opcode      = inst_q[2*WORD_SIZE-1 -: 5];
   assign rx          = inst_q[2*WORD_SIZE-6 -: RB];
   assign ry          = inst_q[2*WORD_SIZE-6-RB -: RB];
   assign imm         = inst_q[WORD_SIZE-1:0];
   assign jump_target = ADDR_SIZE'(imm);
   assign is_alu      = (opcode >= OP_ADD) && (opcode <= OP_XOR);
   assign is_write    = is_alu || (opcode == OP_MOV) || (opcode == OP_SET);
   assign add_full    = {1'b0, op_a_q} + {1'b0, op_b_q};

`ifdef CPU_ILLEGAL_HALT_EN
   logic is_defined;
   assign is_defined = is_alu || (opcode == OP_NOP) || (opcode == OP_MOV) || (opcode == OP_SET) ||
                       (opcode == OP_JMP) || (opcode == OP_JZ) || (opcode == OP_HALT);
`endif

   // Gated with rst so a fetch is never requested while the core is held in reset.
   assign imem_req  = (state_q == S_FETCH) && !rst;
   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign halted    = halted_q;
   assign illegal   = illegal_q;
   assign dbg_data  = regs_q[dbg_idx];

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      case (opcode)
         OP_ADD: begin
            alu_res = add_full[WORD_SIZE-1:0];
            alu_c   = add_full[WORD_SIZE];
         end
         OP_SUB: begin
            alu_res = op_a_q - op_b_q;
            alu_c   = op_a_q < op_b_q;
         end
         OP_AND:  alu_res = op_a_q & op_b_q;
         OP_OR:   alu_res = op_a_q | op_b_q;
         OP_XOR:  alu_res = op_a_q ^ op_b_q;
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      inst_d    = inst_q;
      pc_d      = pc_q;
      regs_d    = regs_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      result_d  = result_q;
      flag_z_d  = flag_z_q;
      flag_c_d  = flag_c_q;
      wr_en_d   = wr_en_q;
      jump_d    = jump_q;
      halted_d  = halted_q;
      illegal_d = illegal_q;
      case (state_q)
         S_FETCH: begin
            if (imem_ack) begin
               inst_d  = imem_data;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            op_a_d  = regs_q[rx];
            op_b_d  = regs_q[ry];
            state_d = S_EXECUTE;
         end
         S_EXECUTE: begin
            wr_en_d = is_write;
            jump_d  = (opcode == OP_JMP) || ((opcode == OP_JZ) && flag_z_q);
            if (is_alu) begin
               result_d = alu_res;
               flag_z_d = (alu_res == '0);
               flag_c_d = alu_c;
            end else if (opcode == OP_MOV) begin
               result_d = op_b_q;
            end else if (opcode == OP_SET) begin
               result_d = imm;
            end
            state_d = S_WRITEBACK;
         end
         S_WRITEBACK: begin
            if (wr_en_q) begin
               regs_d[rx] = result_q;
            end
            if (opcode == OP_HALT) begin
               halted_d = 1'b1;
               state_d  = S_HALT;
            end
`ifdef CPU_ILLEGAL_HALT_EN
            else if (!is_defined) begin
               // pc is left on the offending instruction for post-mortem inspection.
               halted_d  = 1'b1;
               illegal_d = 1'b1;
               state_d   = S_HALT;
            end
`endif
            else begin
               pc_d    = jump_q ? jump_target : pc_q + ADDR_SIZE'(1);
               state_d = S_FETCH;
            end
         end
         S_HALT:  ;
         default: state_d = S_HALT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         inst_q    <= '0;
         pc_q      <= '0;
         for (int i = 0; i < REG_COUNT; i++) begin
            regs_q[i] <= '0;
         end
         op_a_q    <= '0;
         op_b_q    <= '0;
         result_q  <= '0;
         flag_z_q  <= 1'b0;
         flag_c_q  <= 1'b0;
         wr_en_q   <= 1'b0;
         jump_q    <= 1'b0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         inst_q    <= inst_d;
         pc_q      <= pc_d;
         regs_q    <= regs_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         result_q  <= result_d;
         flag_z_q  <= flag_z_d;
         flag_c_q  <= flag_c_d;
         wr_en_q   <= wr_en_d;
         jump_q    <= jump_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
      end
   end

endmodule
